dualedge_stream_sched: RTL and testbench
========================================

// Module: dualedge_stream_sched
// PURPOSE
//   Round-robin scheduler that shares one dual-edge (pos/neg flop) capture datapath between NREQ requesters.
//   It grants one requester at a time and streams that requester's serial bits onto the datapath data input.
//   It drives the datapath path-select (en=1: posedge path, en=0: negedge path) and reports burst completion.
//   Sits directly upstream of the capture datapath; single clock domain.
// PARAMETERS
//   NREQ     4   number of requesters (>=2)
//   LEN_W    4   burst-length field width; burst = req_len+1 bits (1..2**LEN_W)
//   GAP_CYC  2   turnaround cycles after each burst (>=1), dp_en=0 throughout
// PORTS
//   clk        in   1            single clock, rising edge only in this block
//   rst_n      in   1            asynchronous, active-low reset
//   req        in   NREQ         per-requester request level, held until done or abort
//   req_len    in   NREQ*LEN_W   packed burst lengths, slice i = requester i, sampled at grant
//   req_bit    in   NREQ         per-requester serial data bit, valid while own gnt=1
//   gnt        out  NREQ         one-hot grant, registered
//   dp_d       out  1            serial bit to datapath d
//   dp_en      out  1            datapath select; 1 only during STREAM
//   busy       out  1            1 in any state except IDLE
//   done       out  1            1-cycle pulse, first GAP cycle
//   done_id    out  $clog2(NREQ) requester index of the finished burst, valid with done
//   aborted    out  1            valid with done; 1 if req dropped mid-burst
// BEHAVIOUR
//   Reset (async assert): state=IDLE, rr_ptr=0, cnt=0, gap=0, gnt=0, dp_en=0, dp_d=0, busy=0, done=0, done_id=0, aborted=0.
//   Reset deassert mid-burst: the burst is lost; no done is issued for it.
//   States: IDLE -> STREAM -> GAP -> IDLE.
//   IDLE: if |req, pick the first set req at or after rr_ptr (wrapping); latch owner; cnt<=req_len[owner]; gnt[owner]<=1; -> STREAM.
//     No req: stay in IDLE, outputs idle.
//   STREAM: dp_en=1; dp_d=req_bit[owner] (combinational from registered owner/state); cnt decrements each cycle.
//     Last bit when cnt==0: next state is GAP. Exactly req_len+1 STREAM cycles.
//   Abort: req[owner]==0 in any STREAM cycle -> that cycle's bit is not driven (dp_d=0), -> GAP with aborted=1.
//   GAP: gnt=0, dp_en=0, dp_d=0, busy=1; done pulses on the first GAP cycle with done_id=owner.
//     rr_ptr<=owner+1 (mod NREQ) on GAP entry; GAP lasts GAP_CYC cycles, then -> IDLE.
//   req/req_len changes of non-owners during STREAM/GAP are ignored; arbitration only in IDLE.
//   Simultaneous requests: strict round-robin from rr_ptr; no requester waits more than NREQ-1 bursts.
//   Latency: req seen in IDLE at edge k -> gnt and first dp_en at k+1.
//   Minimum grant-to-grant spacing is (len+1)+GAP_CYC+1 cycles.
//   done_id width is $clog2(NREQ); owner index arithmetic wraps modulo NREQ (non-power-of-2 NREQ supported).
// STRUCTURE
//   Shared package dualedge_sched_pkg: state encoding (IDLE/STREAM/GAP), default NREQ/LEN_W/GAP_CYC constants.
//   One sub-module: rr_arbiter (NREQ req + ptr in -> one-hot grant + index out, combinational).
//   The FSM, counters, and output registers live in the top.
// TESTING
//   1 req[2]=1, len=3, bits 1,0,1,1 -> gnt=0100 for 4 cycles, dp_en=1, dp_d=1011; done, done_id=2, aborted=0.
//   2 req=1111 held, rr_ptr=0, len=0 each -> grant order 0,1,2,3,0; each gnt 1 cycle, spacing 1+GAP_CYC+1.
//   3 req[1] dropped after 2 of 8 bits -> dp_en falls that cycle; done with aborted=1, done_id=1; rr_ptr=2.
//   4 len=15 (max) -> exactly 16 STREAM cycles; cnt wrap does not extend the burst.
//   5 rst_n low mid-STREAM -> all outputs 0 immediately; after release with req[3]=1, grant starts from rr_ptr=0 (req[3] is first set).
//   6 req[0] raised during GAP of requester 0 with req[1] also set -> requester 1 wins, requester 0 next.

Source files
------------

// File: rtl/dualedge_sched_pkg.sv
// Shared state encoding and default sizing for the dual-edge stream scheduler.
package dualedge_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2
    } sched_state_e;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_GAP_CYC = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dualedge_stream_sched_if.sv
// Requester-side and datapath-side signals of the scheduler; master drives requests, slave is the scheduler.
interface dualedge_stream_sched_if #(
    parameter int NREQ  = 4,
    parameter int LEN_W = 4,
    parameter int ID_W  = $clog2(NREQ)
) ();
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ-1:0]       req_bit;
    logic [NREQ-1:0]       gnt;
    logic                  dp_d;
    logic                  dp_en;
    logic                  busy;
    logic                  done;
    logic [ID_W-1:0]       done_id;
    logic                  aborted;

    modport master (
        output req, req_len, req_bit,
        input  gnt, dp_d, dp_en, busy, done, done_id, aborted
    );

    modport slave (
        input  req, req_len, req_bit,
        output gnt, dp_d, dp_en, busy, done, done_id, aborted
    );
endinterface

// File: rtl/dualedge_stream_sched_rr_arbiter.sv
// Purpose: round-robin pick of the first set request at or after ptr_i, wrapping modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is used.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [ID_W-1:0] idx_o,
    output logic            vld_o
);
    int   j;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            // Explicit wrap rather than % keeps non-power-of-2 NREQ cheap.
            j = int'(ptr_i) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req_i[j]) begin
                found    = 1'b1;
                idx_o    = ID_W'(j);
                gnt_o[j] = 1'b1;
            end
        end
        vld_o = found;
    end
endmodule

// File: rtl/dualedge_stream_sched.sv
// Purpose: round-robin sharing of one dual-edge capture datapath, streaming the owner's serial bits.
// Latency: request seen in IDLE -> gnt and dp_en on the next cycle; burst = len+1 cycles, then GAP_CYC turnaround.
// Backpressure: none downstream; requesters hold req until done, dropping it mid-burst aborts.
module dualedge_stream_sched
    import dualedge_sched_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int GAP_CYC = DEF_GAP_CYC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dualedge_stream_sched_if.slave  sif
);
    localparam int ID_W  = $clog2(NREQ);
    localparam int GAP_W = safe_clog2(GAP_CYC);

    sched_state_e    state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            done_q, done_d;
    logic [ID_W-1:0] done_id_q, done_id_d;
    logic            aborted_q, aborted_d;

    logic [NREQ-1:0] arb_gnt;
    logic [ID_W-1:0] arb_idx;
    logic            arb_vld;
    logic            owner_req;
    logic            stream_live;
    logic [ID_W-1:0] ptr_next;

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .req_i (sif.req),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    assign owner_req   = sif.req[owner_q];
    assign stream_live = (state_q == ST_STREAM) && owner_req;
    assign ptr_next    = (owner_q == ID_W'(NREQ - 1)) ? '0 : owner_q + ID_W'(1);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        gnt_d     = gnt_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        aborted_d = aborted_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    state_d = ST_STREAM;
                    owner_d = arb_idx;
                    cnt_d   = sif.req_len[arb_idx*LEN_W +: LEN_W];
                    gnt_d   = arb_gnt;
                end
            end
            ST_STREAM: begin
                // A dropped request ends the burst in the same cycle as the last bit would.
                if (!owner_req || (cnt_q == '0)) begin
                    state_d   = ST_GAP;
                    gnt_d     = '0;
                    done_d    = 1'b1;
                    done_id_d = owner_q;
                    aborted_d = !owner_req;
                    rr_ptr_d  = ptr_next;
                    gap_d     = GAP_W'(GAP_CYC - 1);
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            aborted_q <= aborted_d;
        end
    end

    assign sif.gnt     = gnt_q;
    assign sif.dp_en   = stream_live;
    assign sif.dp_d    = stream_live & sif.req_bit[owner_q];
    assign sif.busy    = (state_q != ST_IDLE);
    assign sif.done    = done_q;
    assign sif.done_id = done_id_q;
    assign sif.aborted = aborted_q;
endmodule

// File: tb/tb_dualedge_stream_sched.sv
// Directed bench for dualedge_stream_sched: inputs driven and outputs sampled on the falling edge.
module tb_dualedge_stream_sched;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    dualedge_stream_sched_if #(.NREQ(4), .LEN_W(4)) sif ();

    dualedge_stream_sched #(.NREQ(4), .LEN_W(4), .GAP_CYC(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gnt"},   32'(sif.gnt),   32'h0);
        check({tag, "_dp_en"}, 32'(sif.dp_en), 32'h0);
        check({tag, "_dp_d"},  32'(sif.dp_d),  32'h0);
        check({tag, "_busy"},  32'(sif.busy),  32'h0);
        check({tag, "_done"},  32'(sif.done),  32'h0);
    endtask

    logic [3:0] bits1;
    int         gidx [5];
    int         gcyc [5];
    int         ng;
    int         nstream;
    logic       seen_done;
    int         exp_order [5];

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        sif.req     = '0;
        sif.req_len = '0;
        sif.req_bit = '0;
        exp_order   = '{0, 1, 2, 3, 0};

        // Reset state
        #1;
        check_quiet("rst");
        check("rst_done_id", 32'(sif.done_id), 32'h0);
        check("rst_aborted", 32'(sif.aborted), 32'h0);
        step(); step();
        rst_n = 1'b1;

        // 1: requester 2, len 3, bits 1,0,1,1
        bits1 = 4'b1101;
        step();
        sif.req     = 4'b0100;
        sif.req_len = {4'd0, 4'd3, 4'd0, 4'd0};
        #1 check("t1_idle_busy", 32'(sif.busy), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            sif.req_bit[2] = bits1[i];
            #1;
            check("t1_gnt",   32'(sif.gnt),   32'h4);
            check("t1_dp_en", 32'(sif.dp_en), 32'h1);
            check("t1_dp_d",  32'(sif.dp_d),  32'(bits1[i]));
        end
        step();
        sif.req = '0;
        #1;
        check("t1_done",    32'(sif.done),    32'h1);
        check("t1_done_id", 32'(sif.done_id), 32'h2);
        check("t1_aborted", 32'(sif.aborted), 32'h0);
        check("t1_gap_gnt", 32'(sif.gnt),     32'h0);
        check("t1_gap_en",  32'(sif.dp_en),   32'h0);
        check("t1_gap_busy",32'(sif.busy),    32'h1);
        step();
        #1 check("t1_done_pulse", 32'(sif.done), 32'h0);
        check("t1_gap2_busy", 32'(sif.busy), 32'h1);
        step();
        #1 check("t1_idle", 32'(sif.busy), 32'h0);

        // Reset returns rr_ptr to 0 (it was 3 here)
        step();
        rst_n = 1'b0;
        #1 check_quiet("rst2");
        step();
        rst_n = 1'b1;

        // 2: all requesting, len 0 -> order 0,1,2,3,0 with spacing 4
        step();
        sif.req     = 4'b1111;
        sif.req_len = '0;
        ng = 0;
        for (int c = 1; c <= 30 && ng < 5; c++) begin
            step();
            #1;
            if (sif.gnt != 4'b0000) begin
                check("t2_onehot", 32'($countones(sif.gnt)), 32'h1);
                for (int k = 0; k < 4; k++) begin
                    if (sif.gnt[k]) gidx[ng] = k;
                end
                gcyc[ng] = c;
                ng++;
            end
        end
        check("t2_count", 32'(ng), 32'h5);
        for (int k = 0; k < ng; k++) begin
            check("t2_order", 32'(gidx[k]), 32'(exp_order[k]));
            if (k > 0) check("t2_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'h4);
        end
        step();
        sif.req = '0;
        step();
        step();
        #1 check("t2_idle", 32'(sif.busy), 32'h0);

        // 3: requester 1 drops after 2 of 8 bits (rr_ptr is 1)
        step();
        sif.req     = 4'b0010;
        sif.req_len = {4'd0, 4'd0, 4'd7, 4'd0};
        step();
        sif.req_bit[1] = 1'b1;
        #1 check("t3_gnt", 32'(sif.gnt), 32'h2);
        check("t3_b0", 32'(sif.dp_d), 32'h1);
        step();
        sif.req_bit[1] = 1'b0;
        #1 check("t3_b1_en", 32'(sif.dp_en), 32'h1);
        check("t3_b1", 32'(sif.dp_d), 32'h0);
        step();
        sif.req        = '0;
        sif.req_bit[1] = 1'b1;
        #1 check("t3_abort_en", 32'(sif.dp_en), 32'h0);
        check("t3_abort_d", 32'(sif.dp_d), 32'h0);
        step();
        #1 check("t3_done", 32'(sif.done), 32'h1);
        check("t3_aborted", 32'(sif.aborted), 32'h1);
        check("t3_done_id", 32'(sif.done_id), 32'h1);
        check("t3_gnt_off", 32'(sif.gnt), 32'h0);
        sif.req_bit = '0;
        step();
        step();
        sif.req     = 4'b0110;
        sif.req_len = '0;
        step();
        #1 check("t3_rr_ptr2", 32'(sif.gnt), 32'h4);
        step();
        sif.req = '0;
        step();
        step();
        #1 check("t3_idle", 32'(sif.busy), 32'h0);

        // 4: requester 3, len 15 -> exactly 16 stream cycles
        step();
        sif.req     = 4'b1000;
        sif.req_len = {4'd15, 4'd0, 4'd0, 4'd0};
        nstream   = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            step();
            #1;
            if (sif.dp_en) nstream++;
            if (sif.done) begin
                seen_done = 1'b1;
                check("t4_done_id", 32'(sif.done_id), 32'h3);
                check("t4_aborted", 32'(sif.aborted), 32'h0);
                sif.req = '0;
            end
        end
        check("t4_seen_done", 32'(seen_done), 32'h1);
        check("t4_stream_len", 32'(nstream), 32'd16);
        step();
        step();
        #1 check("t4_idle", 32'(sif.busy), 32'h0);

        // 6: requester 0 re-raises during its own GAP while requester 1 waits
        step();
        sif.req     = 4'b0001;
        sif.req_len = '0;
        step();
        #1 check("t6_gnt0", 32'(sif.gnt), 32'h1);
        step();
        sif.req = '0;
        #1 check("t6_done_id0", 32'(sif.done_id), 32'h0);
        step();
        sif.req = 4'b0011;
        step();
        #1 check("t6_idle", 32'(sif.busy), 32'h0);
        step();
        #1 check("t6_gnt1", 32'(sif.gnt), 32'h2);
        step();
        sif.req = 4'b0001;
        step();
        step();
        step();
        #1 check("t6_gnt0_next", 32'(sif.gnt), 32'h1);
        step();
        sif.req = '0;
        step();
        step();

        // 5: reset mid-STREAM, then req[3] alone after release
        step();
        sif.req     = 4'b0100;
        sif.req_len = {4'd0, 4'd7, 4'd0, 4'd0};
        step();
        step();
        #1 check("t5_streaming", 32'(sif.dp_en), 32'h1);
        step();
        rst_n   = 1'b0;
        sif.req = 4'b1000;
        sif.req_len = '0;
        #1 check_quiet("t5_rst");
        step();
        rst_n = 1'b1;
        step();
        #1 check("t5_gnt3", 32'(sif.gnt), 32'h8);
        step();
        sif.req = '0;
        #1 check("t5_done", 32'(sif.done), 32'h1);
        check("t5_done_id", 32'(sif.done_id), 32'h3);
        step();
        step();
        #1 check("t5_idle", 32'(sif.busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
